mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester of the 5-stage pipeline.
- Sequences each access over a req/ack memory handshake with variable latency.
- Returns read data and completion to the winning requester.
- Drives per-stage stall signals to the hazard/forwarding logic.
- Drops fetch responses cancelled by a taken branch or jump.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported I/D memory between IF fetches and MEM loads/stores.
// Define ARB_FETCH_GUARD_EN to force a fetch grant after STARVE_MAX consecutive fetch losses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  if (((DATA_W % 8) != 0) || (STARVE_MAX < 1)) begin : g_param_check
    $error("mem_port_arbiter: DATA_W must be a multiple of 8 and STARVE_MAX at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                drop_q, drop_d;
  logic                if_ok;
  logic                force_if;
  logic                grant_if;
  logic                grant_dm;

`ifdef ARB_FETCH_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;
`endif

  // A fetch is only eligible when it is not being cancelled this cycle.
  assign if_ok = if_req & ~if_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      drop_q      <= 1'b0;
`ifdef ARB_FETCH_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      drop_q      <= drop_d;
`ifdef ARB_FETCH_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    drop_d      = drop_q;
    force_if    = 1'b0;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
`ifdef ARB_FETCH_GUARD_EN
    starve_d    = starve_q;
    force_if    = if_ok & dm_req & (starve_q == CNT_W'(STARVE_MAX));
`endif
    case (state_q)
      IDLE: begin
        grant_dm = dm_req & ~force_if;
        grant_if = if_ok & ~grant_dm;
        drop_d   = 1'b0;
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_wstrb;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
`ifdef ARB_FETCH_GUARD_EN
        if (grant_if) begin
          starve_d = '0;
        end else if (grant_dm && if_ok && (starve_q != CNT_W'(STARVE_MAX))) begin
          starve_d = starve_q + CNT_W'(1);
        end
`endif
      end
      BUSY_IF: begin
        // The memory cannot abort, so a flushed fetch runs to completion and is discarded.
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    if_rvalid = mem_ack & (state_q == BUSY_IF) & ~drop_q & ~if_flush;
    dm_rvalid = mem_ack & (state_q == BUSY_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    if_stall  = if_req & ~if_rvalid;
    dm_stall  = dm_req & ~dm_rvalid;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a responder models the memory, a monitor checks responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req, if_flush, if_rvalid, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_rvalid, dm_stall;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [STRB_W-1:0] dm_wstrb;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [STRB_W-1:0] mem_wstrb;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
  } resp_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];
  int     checks = 0;
  int     errors = 0;
  int     mem_lat = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0200: return 32'h00A0_0113;
      32'h0000_2000: return 32'h1234_5678;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic void push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                     input logic [3:0] ws);
    grant_t g;
    g.we = we; g.addr = a; g.wdata = wd; g.wstrb = ws;
    exp_grant.push_back(g);
  endfunction

  function automatic void push_resp(input logic is_if, input logic [31:0] d);
    resp_t r;
    r.is_if = is_if; r.data = d;
    exp_resp.push_back(r);
  endfunction

  // Memory model: acks mem_lat cycles after it first sees mem_req, checks each new grant.
  initial begin : responder
    bit          busy;
    bit          stable;
    int          cnt;
    grant_t      g;
    logic [68:0] snap;
    busy = 0; stable = 1; cnt = 0; snap = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (!busy && mem_req) begin
        busy = 1; cnt = mem_lat; stable = 1;
        snap = {mem_we, mem_addr, mem_wdata, mem_wstrb};
        if (exp_grant.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got addr 0x%08h we %0b, expected no grant", mem_addr, mem_we);
        end else begin
          g = exp_grant.pop_front();
          check("grant_we", 32'(mem_we), 32'(g.we));
          check("grant_addr", mem_addr, g.addr);
          if (g.we) begin
            check("grant_wdata", mem_wdata, g.wdata);
            check("grant_wstrb", 32'(mem_wstrb), 32'(g.wstrb));
          end
        end
      end
      if (busy) begin
        if (mem_req && ({mem_we, mem_addr, mem_wdata, mem_wstrb} != snap)) stable = 0;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 32'h0 : mem_data(mem_addr);
          busy = 0;
          check("mem_stable", 32'(stable), 32'd1);
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (if_rvalid || dm_rvalid) begin
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_unexpected: got if_rvalid=%0b dm_rvalid=%0b, expected none",
                   if_rvalid, dm_rvalid);
        end else begin
          r = exp_resp.pop_front();
          check("resp_port", {30'd0, if_rvalid, dm_rvalid}, r.is_if ? 32'd2 : 32'd1);
          check("resp_data", if_rvalid ? if_rdata : dm_rdata, r.data);
          check("resp_other_rdata", if_rvalid ? dm_rdata : if_rdata, 32'h0);
        end
      end
    end
  end

  task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
    bit ok = 0;
    bit stall_ok = 1;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_wstrb = ws;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dm_stall !== !dm_rvalid) stall_ok = 0;
      if (dm_rvalid) begin ok = 1; break; end
    end
    check("dm_done", 32'(ok), 32'd1);
    check("dm_stall_track", 32'(stall_ok), 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
  endtask

  task automatic if_access(input logic [31:0] a);
    bit ok = 0;
    bit stall_ok = 1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_stall !== !if_rvalid) stall_ok = 0;
      if (if_rvalid) begin ok = 1; break; end
    end
    check("if_done", 32'(ok), 32'd1);
    check("if_stall_track", 32'(stall_ok), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin : stimulus
    bit late;
    bit ok;
    bit lower_if;
    int ngr;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait fetch of 0x100.
    mem_lat = 0;
    push_grant(1'b0, 32'h100, 32'h0, 4'h0);
    push_resp(1'b1, 32'h0050_0093);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("zw_stall_t", 32'(if_stall), 32'd1);
    check("zw_mem_req_t", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("zw_rvalid_t1", 32'(if_rvalid), 32'd1);
    check("zw_stall_t1", 32'(if_stall), 32'd0);
    check("zw_mem_addr_t1", mem_addr, 32'h100);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
    @(negedge clk);
    check("zw_mem_req_idle", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);

    // Simultaneous load and fetch: load wins, fetch follows.
    mem_lat = 1;
    push_grant(1'b0, 32'h2000, 32'h0, 4'h0);
    push_grant(1'b0, 32'h108, 32'h0, 4'h0);
    push_resp(1'b0, 32'h1234_5678);
    push_resp(1'b1, 32'h5A5A_0108);
    fork
      dm_access(1'b0, 32'h2000, 32'h0, 4'h0);
      if_access(32'h108);
    join
    repeat (2) @(posedge clk);

    // Store with ack in the third request cycle.
    mem_lat = 2;
    push_grant(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3);
    push_resp(1'b0, 32'h0);
    dm_access(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3);
    repeat (2) @(posedge clk);

    // Fetch of 0x104 flushed while in flight, then redirected fetch of 0x200.
    mem_lat = 1;
    push_grant(1'b0, 32'h104, 32'h0, 4'h0);
    push_grant(1'b0, 32'h200, 32'h0, 4'h0);
    push_resp(1'b1, 32'h00A0_0113);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h104;
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h200;
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    check("flush_ack_seen", 32'(mem_ack), 32'd1);
    check("flush_no_rvalid", 32'(if_rvalid), 32'd0);
    check("flush_stall", 32'(if_stall), 32'd1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_rvalid) begin ok = 1; break; end
    end
    check("flush_refetch_done", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0;
    repeat (2) @(posedge clk);

    // Reset during a load; the late ack must be ignored.
    mem_lat = 6;
    push_grant(1'b0, 32'h2008, 32'h0, 4'h0);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_addr = 32'h2008;
    @(posedge clk); #1;
    check("rst_busy_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0; dm_req = 1'b0; dm_addr = '0;
    #1;
    check("rst_async_req", 32'(mem_req), 32'd0);
    check("rst_async_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    late = 0;
    repeat (8) begin
      @(negedge clk);
      if (dm_rvalid) late = 1;
    end
    check("rst_late_ack_ignored", 32'(late), 32'd0);
    repeat (2) @(posedge clk);

    // Both requesters held: grant order depends on the fetch guard.
    mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FETCH_GUARD_EN
      if (i == 4) begin
        push_grant(1'b0, 32'h400, 32'h0, 4'h0);
        push_resp(1'b1, 32'h5A5A_0400);
      end else begin
        push_grant(1'b0, 32'h3000, 32'h0, 4'h0);
        push_resp(1'b0, 32'h5A5A_3000);
      end
`else
      push_grant(1'b0, 32'h3000, 32'h0, 4'h0);
      push_resp(1'b0, 32'h5A5A_3000);
`endif
    end
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    if_req = 1'b1; if_addr = 32'h400;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      @(negedge clk);
      lower_if = 0;
      if (dm_rvalid) ngr++;
      if (if_rvalid) begin ngr++; lower_if = 1; end
      @(posedge clk); #1;
      if (lower_if) if_req = 1'b0;
      if (ngr == 6) begin
        dm_req = 1'b0; dm_addr = '0; if_req = 1'b0; if_addr = '0;
      end
    end
    check("guard_grant_count", 32'(ngr), 32'd6);
    repeat (4) @(posedge clk);

    check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
